instr_cycle_sequencer: RTL

//  Parametrised per-instruction clock-cycle sequencer for the CPU core. Takes a start pulse plus an

---
 rtl/instr_cycle_sequencer_if.sv | 39 +++
 rtl/instr_cycle_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/instr_cycle_sequencer_if.sv
// Decoder-side handshake bundle for instr_cycle_sequencer.
// The stall_i wire exists only when SEQ_STALL_EN is defined.
interface instr_cycle_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             clk_en_i;
    logic             start_i;
    logic [1:0]       len_sel_i;
    logic             halt_req_i;
    logic             wake_i;
`ifdef SEQ_STALL_EN
    logic             stall_i;
`endif
    logic             busy_o;
    logic             halted_o;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic             reg_fetch_o;
    logic             reg_write_o;
    logic             instr_done_o;
    logic             issue_err_o;

    modport master (
`ifdef SEQ_STALL_EN
        output stall_i,
`endif
        output clk_en_i, start_i, len_sel_i, halt_req_i, wake_i,
        input  busy_o, halted_o, cycle_cnt_o, reg_fetch_o, reg_write_o,
        input  instr_done_o, issue_err_o
    );

    modport slave (
`ifdef SEQ_STALL_EN
        input  stall_i,
`endif
        input  clk_en_i, start_i, len_sel_i, halt_req_i, wake_i,
        output busy_o, halted_o, cycle_cnt_o, reg_fetch_o, reg_write_o,
        output instr_done_o, issue_err_o
    );
endinterface

// File: rtl/instr_cycle_sequencer.sv
// Per-instruction cycle sequencer: counts clock-enabled cycles and emits fetch/write/done strobes.
// Optional feature macro: SEQ_STALL_EN (adds a stall input that freezes the sequencer).
module instr_cycle_sequencer #(
    parameter int CNT_W     = 4,
    parameter int LEN_A     = 5,
    parameter int LEN_B     = 7,
    parameter int LEN_C     = 12,
    parameter int FETCH_IDX = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    instr_cycle_sequencer_if.slave   seq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Lengths are held as last-cycle indices so the done compare needs no subtract.
    localparam logic [CNT_W-1:0] LAST_A  = CNT_W'(LEN_A - 1);
    localparam logic [CNT_W-1:0] LAST_B  = CNT_W'(LEN_B - 1);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(LEN_C - 1);
    localparam logic [CNT_W-1:0] FETCH_C = CNT_W'(FETCH_IDX);

    function automatic logic [CNT_W-1:0] last_idx(input logic [1:0] sel);
        logic [CNT_W-1:0] r;
        case (sel)
            2'd0:    r = LAST_A;
            2'd1:    r = LAST_B;
            2'd2:    r = LAST_C;
            default: r = LAST_C;
        endcase
        return r;
    endfunction

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] last_q;
    logic             busy_q;
    logic             halted_q;
    logic             err_q;

    logic             stall_s;
    logic             adv_s;
    logic             run_s;
    logic             at_last_s;
    logic             at_write_s;
    logic             at_fetch_s;

`ifdef SEQ_STALL_EN
    assign stall_s = seq.stall_i;
`else
    assign stall_s = 1'b0;
`endif

    // Decode of the registered state against the enable qualifier.
    always_comb begin
        adv_s      = seq.clk_en_i & ~stall_s;
        run_s      = (state_q == ST_RUN);
        at_last_s  = (cnt_q == last_q);
        at_write_s = (cnt_q == (last_q - CNT_W'(1)));
        at_fetch_s = (cnt_q == FETCH_C);
    end

    // Sequencer FSM, counter, latched length and sticky issue error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            last_q   <= LAST_A;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (adv_s) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= {CNT_W{1'b0}};
                    if (seq.start_i) begin
                        state_q <= ST_RUN;
                        last_q  <= last_idx(seq.len_sel_i);
                        busy_q  <= 1'b1;
                    end else if (seq.halt_req_i) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (at_last_s) begin
                        // Start wins over halt so back-to-back issue has no bubble.
                        cnt_q <= {CNT_W{1'b0}};
                        if (seq.start_i) begin
                            last_q <= last_idx(seq.len_sel_i);
                        end else if (seq.halt_req_i) begin
                            state_q  <= ST_HALT;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (seq.start_i) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    cnt_q <= {CNT_W{1'b0}};
                    if (seq.wake_i) begin
                        state_q  <= ST_IDLE;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= {CNT_W{1'b0}};
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign seq.busy_o       = busy_q;
    assign seq.halted_o     = halted_q;
    assign seq.cycle_cnt_o  = cnt_q;
    assign seq.issue_err_o  = err_q;
    // Strobes are qualified by the live enable so each fires on exactly one clock.
    assign seq.reg_fetch_o  = run_s & adv_s & at_fetch_s;
    assign seq.reg_write_o  = run_s & adv_s & at_write_s;
    assign seq.instr_done_o = run_s & adv_s & at_last_s;

endmodule
